// File: rtl/snitch_icache_refill_merge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snitch_icache_refill_merge: merges concurrent L0 refills to the same line
// Revision: 1.0
// ---------------------------------------------------------------------------
module snitch_icache_refill_merge #(
  parameter int unsigned FETCH_AW      = 32,
  parameter int unsigned LINE_WIDTH    = 128,
  parameter int unsigned LINE_ALIGN    = 4,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned PENDING_DEPTH = 4,
  localparam int unsigned TAG_W        = $clog2(PENDING_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FETCH_AW-1:0]   in_req_addr_i,
  input  logic [ID_WIDTH-1:0]   in_req_id_i,
  input  logic                  in_req_valid_i,
  output logic                  in_req_ready_o,
  output logic [LINE_WIDTH-1:0] in_rsp_data_o,
  output logic                  in_rsp_error_o,
  output logic [ID_WIDTH-1:0]   in_rsp_id_o,
  output logic                  in_rsp_valid_o,
  input  logic                  in_rsp_ready_i,
  output logic [FETCH_AW-1:0]   out_req_addr_o,
  output logic [TAG_W-1:0]      out_req_tag_o,
  output logic                  out_req_valid_o,
  input  logic                  out_req_ready_i,
  input  logic [LINE_WIDTH-1:0] out_rsp_data_i,
  input  logic                  out_rsp_error_i,
  input  logic [TAG_W-1:0]      out_rsp_tag_i,
  input  logic                  out_rsp_valid_i,
  output logic                  out_rsp_ready_o
);

  localparam int unsigned LA_W = FETCH_AW - LINE_ALIGN;

  logic [PENDING_DEPTH-1:0] valid_q, valid_d;
  logic [LA_W-1:0]          line_q [PENDING_DEPTH];
  logic [LA_W-1:0]          line_d [PENDING_DEPTH];
  logic [ID_WIDTH-1:0]      mask_q [PENDING_DEPTH];
  logic [ID_WIDTH-1:0]      mask_d [PENDING_DEPTH];
  logic                     out_valid_q, out_valid_d;
  logic [FETCH_AW-1:0]      out_addr_q, out_addr_d;
  logic [TAG_W-1:0]         out_tag_q, out_tag_d;

  logic [LA_W-1:0]  req_line;
  logic             rsp_fire;
  logic             hit, freeing_hit, free_found, out_slot_ok;
  logic [TAG_W-1:0] hit_idx, free_idx;
  logic             req_fire, merge_fire, alloc_fire;
  logic             unused_offset;

  assign req_line      = in_req_addr_i[FETCH_AW-1:LINE_ALIGN];
  assign unused_offset = ^in_req_addr_i[LINE_ALIGN-1:0];
  assign rsp_fire      = out_rsp_valid_i & in_rsp_ready_i;
  assign out_slot_ok   = ~out_valid_q | out_req_ready_i;

  // Lookup: an entry retiring this cycle is not a merge target; its line
  // must wait a cycle and then allocate afresh.
  always_comb begin
    hit         = 1'b0;
    hit_idx     = '0;
    freeing_hit = 1'b0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = 0; i < int'(PENDING_DEPTH); i++) begin
      if (valid_q[i] && (line_q[i] == req_line)) begin
        if (rsp_fire && (out_rsp_tag_i == TAG_W'(i))) begin
          freeing_hit = 1'b1;
        end else begin
          hit     = 1'b1;
          hit_idx = TAG_W'(i);
        end
      end
    end
    for (int i = int'(PENDING_DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = TAG_W'(i);
      end
    end
  end

  assign in_req_ready_o = freeing_hit ? 1'b0 :
                          hit         ? 1'b1 : (free_found & out_slot_ok);
  assign req_fire   = in_req_valid_i & in_req_ready_o;
  assign merge_fire = req_fire & hit;
  assign alloc_fire = req_fire & ~hit;

  assign in_rsp_valid_o  = out_rsp_valid_i;
  assign in_rsp_data_o   = out_rsp_data_i;
  assign in_rsp_error_o  = out_rsp_error_i;
  assign out_rsp_ready_o = in_rsp_ready_i;
  assign in_rsp_id_o     = mask_q[out_rsp_tag_i] |
                           ((merge_fire && (hit_idx == out_rsp_tag_i)) ? in_req_id_i : '0);

  assign out_req_valid_o = out_valid_q;
  assign out_req_addr_o  = out_addr_q;
  assign out_req_tag_o   = out_tag_q;

  always_comb begin
    valid_d     = valid_q;
    line_d      = line_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_tag_d   = out_tag_q;
    if (out_valid_q && out_req_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (rsp_fire) begin
      valid_d[out_rsp_tag_i] = 1'b0;
      mask_d[out_rsp_tag_i]  = '0;
    end
    if (merge_fire) begin
      mask_d[hit_idx] = mask_q[hit_idx] | in_req_id_i;
    end
    // The allocated entry is never the one retiring: that one is still valid_q.
    if (alloc_fire) begin
      valid_d[free_idx] = 1'b1;
      line_d[free_idx]  = req_line;
      mask_d[free_idx]  = in_req_id_i;
      out_valid_d       = 1'b1;
      out_addr_d        = {req_line, {LINE_ALIGN{1'b0}}};
      out_tag_d         = free_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_tag_q   <= '0;
      for (int i = 0; i < int'(PENDING_DEPTH); i++) begin
        line_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      line_q      <= line_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_tag_q   <= out_tag_d;
    end
  end

  rsp_tag_valid: assert property (@(posedge clk_i) disable iff (rst_i)
                                  rsp_fire |-> valid_q[out_rsp_tag_i]);

endmodule
`default_nettype wire

// File: tb/tb_snitch_icache_refill_merge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_snitch_icache_refill_merge: directed self-checking bench
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_snitch_icache_refill_merge;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_req_addr;
  logic [7:0]   in_req_id;
  logic         in_req_valid, in_req_ready;
  logic [127:0] in_rsp_data;
  logic         in_rsp_error;
  logic [7:0]   in_rsp_id;
  logic         in_rsp_valid, in_rsp_ready;
  logic [31:0]  out_req_addr;
  logic [1:0]   out_req_tag;
  logic         out_req_valid, out_req_ready;
  logic [127:0] out_rsp_data;
  logic         out_rsp_error;
  logic [1:0]   out_rsp_tag;
  logic         out_rsp_valid, out_rsp_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  snitch_icache_refill_merge dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_req_addr_i   (in_req_addr),
    .in_req_id_i     (in_req_id),
    .in_req_valid_i  (in_req_valid),
    .in_req_ready_o  (in_req_ready),
    .in_rsp_data_o   (in_rsp_data),
    .in_rsp_error_o  (in_rsp_error),
    .in_rsp_id_o     (in_rsp_id),
    .in_rsp_valid_o  (in_rsp_valid),
    .in_rsp_ready_i  (in_rsp_ready),
    .out_req_addr_o  (out_req_addr),
    .out_req_tag_o   (out_req_tag),
    .out_req_valid_o (out_req_valid),
    .out_req_ready_i (out_req_ready),
    .out_rsp_data_i  (out_rsp_data),
    .out_rsp_error_i (out_rsp_error),
    .out_rsp_tag_i   (out_rsp_tag),
    .out_rsp_valid_i (out_rsp_valid),
    .out_rsp_ready_o (out_rsp_ready)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] a, input logic [7:0] id,
                          input logic exp_rdy, input string nm);
    in_req_addr  = a;
    in_req_id    = id;
    in_req_valid = 1'b1;
    @(negedge clk);
    chk(nm, in_req_ready, exp_rdy);
    step();
    in_req_valid = 1'b0;
  endtask

  task automatic exp_oreq(input logic v, input logic [31:0] a, input logic [1:0] t,
                          input string nm);
    @(negedge clk);
    chk({nm, "_valid"}, out_req_valid, v);
    if (v) begin
      chk({nm, "_addr"}, out_req_addr, a);
      chk({nm, "_tag"}, out_req_tag, t);
    end
    step();
  endtask

  task automatic send_rsp(input logic [1:0] t, input logic [127:0] d, input logic e,
                          input logic [7:0] exp_id, input string nm);
    out_rsp_tag   = t;
    out_rsp_data  = d;
    out_rsp_error = e;
    out_rsp_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_valid"}, in_rsp_valid, 1'b1);
    chk({nm, "_id"}, in_rsp_id, exp_id);
    chk({nm, "_data"}, in_rsp_data, d);
    chk({nm, "_err"}, in_rsp_error, e);
    chk({nm, "_ordy"}, out_rsp_ready, 1'b1);
    step();
    out_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_req_addr = '0; in_req_id = '0; in_req_valid = 1'b0;
    in_rsp_ready = 1'b1; out_req_ready = 1'b1;
    out_rsp_data = '0; out_rsp_error = 1'b0; out_rsp_tag = '0; out_rsp_valid = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_oreq_valid", out_req_valid, 1'b0);
    chk("rst_oreq_addr", out_req_addr, 32'h0);
    chk("rst_oreq_tag", out_req_tag, 2'd0);
    chk("rst_irsp_valid", in_rsp_valid, 1'b0);
    step();
    rst = 1'b0;

    // Single miss, then response frees entry 0
    send_req(32'h1004, 8'h01, 1'b1, "t1_rdy");
    exp_oreq(1'b1, 32'h1000, 2'd0, "t1_oreq");
    exp_oreq(1'b0, 32'h0, 2'd0, "t1_drop");
    send_rsp(2'd0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b0, 8'h01, "t1_rsp");

    // Merge two requests on one line; entry 0 reused
    send_req(32'h2000, 8'h01, 1'b1, "t2_rdy_a");
    exp_oreq(1'b1, 32'h2000, 2'd0, "t2_oreq");
    send_req(32'h200C, 8'h04, 1'b1, "t2_rdy_merge");
    exp_oreq(1'b0, 32'h0, 2'd0, "t2_no_oreq");
    send_rsp(2'd0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b0, 8'h05, "t2_rsp");

    // Fill all four entries
    send_req(32'h3000, 8'h01, 1'b1, "t3_rdy0");
    exp_oreq(1'b1, 32'h3000, 2'd0, "t3_o0");
    send_req(32'h4000, 8'h02, 1'b1, "t3_rdy1");
    exp_oreq(1'b1, 32'h4000, 2'd1, "t3_o1");
    send_req(32'h5000, 8'h04, 1'b1, "t3_rdy2");
    exp_oreq(1'b1, 32'h5000, 2'd2, "t3_o2");
    send_req(32'h6000, 8'h08, 1'b1, "t3_rdy3");
    exp_oreq(1'b1, 32'h6000, 2'd3, "t3_o3");
    send_req(32'h7000, 8'h10, 1'b0, "t3_full_a");
    send_req(32'h7000, 8'h10, 1'b0, "t3_full_b");
    // Error response frees entry 2, but not for reuse in the same cycle
    in_req_addr = 32'h7000; in_req_id = 8'h10; in_req_valid = 1'b1;
    out_rsp_tag = 2'd2; out_rsp_data = 128'hE; out_rsp_error = 1'b1; out_rsp_valid = 1'b1;
    @(negedge clk);
    chk("t3_free_same_cyc", in_req_ready, 1'b0);
    chk("t3_err_id", in_rsp_id, 8'h04);
    chk("t3_err_flag", in_rsp_error, 1'b1);
    step();
    out_rsp_valid = 1'b0; out_rsp_error = 1'b0; in_req_valid = 1'b0;
    send_req(32'h7000, 8'h10, 1'b1, "t3_realloc");
    exp_oreq(1'b1, 32'h7000, 2'd2, "t3_o_realloc");
    send_rsp(2'd3, 128'h33, 1'b0, 8'h08, "t3_rsp3");
    send_rsp(2'd0, 128'h00, 1'b0, 8'h01, "t3_rsp0");
    send_rsp(2'd1, 128'h11, 1'b0, 8'h02, "t3_rsp1");
    send_rsp(2'd2, 128'h22, 1'b0, 8'h10, "t3_rsp2");

    // Downstream backpressure
    out_req_ready = 1'b0;
    send_req(32'h8000, 8'h01, 1'b1, "t4_rdy");
    send_req(32'h9000, 8'h02, 1'b0, "t4_stall");
    send_req(32'h8008, 8'h04, 1'b1, "t4_merge");
    exp_oreq(1'b1, 32'h8000, 2'd0, "t4_stable");
    out_req_ready = 1'b1;
    exp_oreq(1'b1, 32'h8000, 2'd0, "t4_hs");
    exp_oreq(1'b0, 32'h0, 2'd0, "t4_drop");
    send_rsp(2'd0, 128'h88, 1'b0, 8'h05, "t4_rsp");

    // Request to a line retiring this cycle
    send_req(32'hA000, 8'h01, 1'b1, "t5_rdy0");
    exp_oreq(1'b1, 32'hA000, 2'd0, "t5_o0");
    send_req(32'hB000, 8'h02, 1'b1, "t5_rdy1");
    exp_oreq(1'b1, 32'hB000, 2'd1, "t5_o1");
    in_req_addr = 32'hB004; in_req_id = 8'h08; in_req_valid = 1'b1;
    out_rsp_tag = 2'd1; out_rsp_data = 128'hBB; out_rsp_valid = 1'b1;
    @(negedge clk);
    chk("t5_block", in_req_ready, 1'b0);
    chk("t5_rsp_id", in_rsp_id, 8'h02);
    step();
    out_rsp_valid = 1'b0; in_req_valid = 1'b0;
    send_req(32'hB004, 8'h08, 1'b1, "t5_retry");
    exp_oreq(1'b1, 32'hB000, 2'd1, "t5_o_retry");

    // Upstream response backpressure keeps the entry
    in_rsp_ready = 1'b0;
    out_rsp_tag = 2'd1; out_rsp_data = 128'hCC; out_rsp_valid = 1'b1;
    @(negedge clk);
    chk("t6_ordy_low", out_rsp_ready, 1'b0);
    chk("t6_irsp_valid", in_rsp_valid, 1'b1);
    step();
    out_rsp_valid = 1'b0; in_rsp_ready = 1'b1;
    send_req(32'hB000, 8'h04, 1'b1, "t6_still_valid");
    exp_oreq(1'b0, 32'h0, 2'd0, "t6_no_oreq");
    out_req_ready = 1'b0;
    send_req(32'hC000, 8'h01, 1'b1, "t6_rdy2");
    exp_oreq(1'b1, 32'hC000, 2'd2, "t6_o2");

    // Reset with three entries pending
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("t7_rst_valid", out_req_valid, 1'b0);
    chk("t7_rst_addr", out_req_addr, 32'h0);
    chk("t7_rst_tag", out_req_tag, 2'd0);
    step();
    rst = 1'b0; out_req_ready = 1'b1;
    send_req(32'hA000, 8'h02, 1'b1, "t7_rdy");
    exp_oreq(1'b1, 32'hA000, 2'd0, "t7_o0");
    send_rsp(2'd0, 128'hAA, 1'b0, 8'h02, "t7_rsp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snitch_icache_refill_merge.md
SNITCH_ICACHE_REFILL_MERGE -- requirements
Module: snitch_icache_refill_merge

Interface
REQ-001 SHALL have parameter FETCH_AW, default 32, fetch/refill address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, refill line data width.
REQ-003 SHALL have parameter LINE_ALIGN, default 4, log2 of line bytes.
REQ-004 SHALL have parameter ID_WIDTH, default 8, requester ID mask width (one bit per L0 port/prefetch source).
REQ-005 SHALL have parameter PENDING_DEPTH, default 4 (power of two, >=2), outstanding-line table entries; TAG_W = log2(PENDING_DEPTH).
REQ-006 clk_i  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 in_req_addr_i  in  FETCH_AW  refill request address from L0 side.
REQ-009 in_req_id_i  in  ID_WIDTH  requester ID mask, nonzero.
REQ-010 in_req_valid_i / in_req_ready_o  in/out  1  request handshake.
REQ-011 in_rsp_data_o  out  LINE_WIDTH; in_rsp_error_o  out  1; in_rsp_id_o  out  ID_WIDTH (merged mask); in_rsp_valid_o out 1; in_rsp_ready_i in 1.
REQ-012 out_req_addr_o  out  FETCH_AW; out_req_tag_o  out  TAG_W; out_req_valid_o out 1; out_req_ready_i in 1.
REQ-013 out_rsp_data_i  in  LINE_WIDTH; out_rsp_error_i in 1; out_rsp_tag_i in TAG_W; out_rsp_valid_i in 1; out_rsp_ready_o out 1.

Function
REQ-014 SHALL hold per entry: valid bit, line address (FETCH_AW-LINE_ALIGN bits), ID mask.
REQ-015 Line address of a request SHALL be in_req_addr_i >> LINE_ALIGN; the line offset bits SHALL be ignored for matching.
REQ-016 Match: valid entry with equal line address and not being freed this cycle; at most one entry SHALL ever match.
REQ-017 On match, in_req_ready_o SHALL be 1 same cycle and on handshake the entry mask SHALL be ORed with in_req_id_i; no downstream request issued.
REQ-018 If the request's line equals an entry being freed this cycle (out_rsp handshake with that tag), in_req_ready_o SHALL be 0 that cycle.
REQ-019 On no match, in_req_ready_o SHALL be 1 iff a free entry exists and the out_req register is empty or handshaking this cycle.
REQ-020 Allocation SHALL pick the lowest-index free entry; entry freed this cycle SHALL NOT be reusable until next cycle.
REQ-021 Allocation SHALL load out_req register: out_req_valid_o=1 next cycle, out_req_addr_o = line address << LINE_ALIGN (low LINE_ALIGN bits 0), out_req_tag_o = entry index.
REQ-022 out_req_valid_o and payload SHALL stay stable until out_req_ready_i; valid drops the cycle after handshake unless a new allocation reloads it.
REQ-023 in_rsp path SHALL be combinational: in_rsp_valid_o = out_rsp_valid_i; data/error pass through; in_rsp_id_o = mask of entry out_rsp_tag_i, including a merge handshaking the same cycle.
REQ-024 out_rsp_ready_o SHALL equal in_rsp_ready_i; on out_rsp handshake entry out_rsp_tag_i SHALL be invalidated.
REQ-025 Error responses SHALL free the entry identically to good responses.
REQ-026 Response for an invalid tag SHALL be an assertion failure; no state change specified.
REQ-027 Responses SHALL be accepted in any tag order.

Reset
REQ-028 While rst_i=1 at a clock edge: all entries invalid, masks 0, out_req_valid_o=0, out_req_addr_o=0, out_req_tag_o=0.
REQ-029 After reset in_req_ready_o SHALL be 1 for any valid request; in_rsp_valid_o follows out_rsp_valid_i.
REQ-030 Reset mid-operation SHALL discard all pending entries; late responses are not the block's concern.

Verification
REQ-031 Req 0x1004 id 0x01 -> next cycle out_req addr 0x1000 tag 0; rsp tag 0 data D -> in_rsp id 0x01 data D, entry 0 freed.
REQ-032 Req 0x2000 id 0x01, then 0x200C id 0x04 -> single out_req 0x2000; rsp -> in_rsp id 0x05.
REQ-033 Four distinct lines, out_req_ready_i=1 -> tags 0,1,2,3; fifth distinct line -> in_req_ready_o=0 until a response frees an entry.
REQ-034 out_req_ready_i=0 for 3 cycles -> out_req addr/tag stable; second distinct request stalled; merge requests still accepted.
REQ-035 Rsp tag 1 handshake same cycle as req matching entry 1 -> in_req_ready_o=0; next cycle request allocates new entry and issues out_req.
REQ-036 in_rsp_ready_i=0 with rsp valid -> out_rsp_ready_o=0, entry stays valid; rst_i pulse with 3 pending -> all entries freed, out_req_valid_o=0.
